umi_reg_host: RTL and testbench
===============================

# umi_reg_host

Host-side UMI register initiator: converts a single-outstanding register read/write request into a UMI request packet, waits for the matching UMI response and returns read data and error status on a simple register port. It sits between a local controller (CPU bridge, JTAG/config sequencer) and the UMI host port of a fabric whose far end is a UMI device-side register interface. One transaction is in flight at a time, and a response timeout guarantees forward progress.

## Interface
- AW, 64, UMI address width
- CW, 32, UMI command width
- DW, 256, UMI data width; must be a multiple of RW
- RW, 64, register data width
- HOSTID, 0, 5-bit hostid packed into every request cmd
- TIMEOUT, 1024, response timeout in cycles; 0 disables the timeout
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- reg_valid  input  1  register request valid
- reg_ready  output  1  register request accepted when reg_valid & reg_ready
- reg_write  input  1  1=write, 0=read
- reg_posted  input  1  with reg_write=1, issue a posted write (no response)
- reg_addr  input  AW  target address (UMI dstaddr)
- reg_srcaddr  input  AW  return address (UMI srcaddr)
- reg_size  input  3  UMI size field (0=byte … 3=64b)
- reg_wrdata  input  RW  write data
- reg_done  output  1  one-cycle completion pulse
- reg_rddata  output  RW  read data, valid with reg_done, held until next reg_done
- reg_err  output  2  completion status, valid with reg_done, held until next reg_done
- uhost_req_valid  output  1  UMI request valid
- uhost_req_cmd  output  CW  UMI request command
- uhost_req_dstaddr  output  AW  UMI request dstaddr
- uhost_req_srcaddr  output  AW  UMI request srcaddr
- uhost_req_data  output  DW  UMI request data
- uhost_req_ready  input  1  UMI request ready
- uhost_resp_valid  input  1  UMI response valid
- uhost_resp_cmd  input  CW  UMI response command
- uhost_resp_dstaddr  input  AW  UMI response dstaddr
- uhost_resp_srcaddr  input  AW  UMI response srcaddr (unused)
- uhost_resp_data  input  DW  UMI response data
- uhost_resp_ready  output  1  UMI response ready

## Operation
- States: IDLE, REQ, RESP. Reset enters IDLE.
- IDLE: reg_ready=1. On reg_valid&reg_ready, capture addr, srcaddr, size, wrdata, write and posted flags; go to REQ.
- REQ: uhost_req_valid=1 with fields stable. cmd is built with umi_pack: opcode UMI_REQ_READ (read), UMI_REQ_WRITE (write) or UMI_REQ_POSTED (posted write); size=reg_size, len=0, eom=1, eof=1, hostid=HOSTID, all other fields 0. dstaddr=reg_addr, srcaddr=reg_srcaddr, data={DW/RW{reg_wrdata}}. On uhost_req_ready: a posted write goes to IDLE with reg_done and reg_err=0 (reg_rddata unchanged); otherwise go to RESP and clear the timeout counter.
- RESP: consume the first uhost_resp_valid beat. The expected opcode is UMI_RESP_READ for a read and UMI_RESP_WRITE for a write, unpacked with umi_unpack.
  - Expected opcode and dstaddr equal to the captured srcaddr: reg_err = cmd err field; reg_rddata = resp_data[RW-1:0] for a read, unchanged for a write.
  - Opcode or dstaddr mismatch: reg_err=2'b10, reg_rddata unchanged.
  - In either case, pulse reg_done and return to IDLE.
- Timeout: the counter increments each RESP cycle without a response. On reaching TIMEOUT-1 with no response that cycle, pulse reg_done with reg_err=2'b11, leave reg_rddata unchanged, return to IDLE. A response in the same cycle as expiry wins.
- uhost_resp_ready=1 in every state after reset. Beats arriving in IDLE or REQ are stray (late or unsolicited) and are consumed and discarded.

## Timing
- All outputs are registered or decoded from registered state.
- Values while reset is asserted: reg_ready=0, reg_done=0, reg_rddata=0, reg_err=0, uhost_req_valid=0, uhost_req_cmd/dstaddr/srcaddr/data=0, uhost_resp_ready=0.
- reg_ready rises in the first cycle after reset deasserts.
- Accept at edge N: uhost_req_valid is high from cycle N+1.
- Request handshake at edge M:
  - Posted write: reg_done is high in cycle M+1 and reg_ready is high in M+1.
  - Otherwise: RESP starts in M+1.
- Response handshake at edge K: reg_done is high in cycle K+1 and reg_ready is high in K+1.
- Minimum read latency, from reg accept to reg_done, is 3 cycles.
- reg_valid while busy is ignored (reg_ready=0) and holds until accepted.
- Back-to-back: the next reg request can be accepted in the reg_done cycle.
- Reset mid-transaction aborts immediately: no reg_done, and any in-flight uhost_req_valid drops asynchronously.

## Test plan
- Read, immediate ready and response, device returns data 64'h1234_5678_9ABC_DEF0 -> req cmd opcode UMI_REQ_READ, hostid=HOSTID; reg_done 3 cycles after accept with that rddata, err=0.
- Write addr 0x100, data 0xA5, uhost_req_ready held low 4 cycles -> req fields stable throughout; RESP_WRITE response -> reg_done, err=0, rddata unchanged.
- Posted write -> opcode UMI_REQ_POSTED; reg_done the cycle after req handshake; no response consumed.
- Read, response with UMI_RESP_WRITE opcode or wrong dstaddr -> reg_err=2'b10; a response with err field 2'b01 -> reg_err=2'b01.
- TIMEOUT=16, no response -> reg_done with err=2'b11 after 16 RESP cycles; a late response in IDLE is discarded; the next read completes normally.
- Reset asserted in RESP -> outputs at reset values; after release, reg_ready=1 and a new read completes.

Source files
------------

// File: rtl/umi_reg_host.sv
`default_nettype none
// ============================================================================
// umi_reg_host : single-outstanding UMI register initiator with response timeout
// Rev 1.0
// ============================================================================
module umi_reg_host #(
   parameter int AW      = 64,
   parameter int CW      = 32,
   parameter int DW      = 256,
   parameter int RW      = 64,
   parameter int HOSTID  = 0,
   parameter int TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          reset,
   // register port
   input  logic          reg_valid,
   output logic          reg_ready,
   input  logic          reg_write,
   input  logic          reg_posted,
   input  logic [AW-1:0] reg_addr,
   input  logic [AW-1:0] reg_srcaddr,
   input  logic [2:0]    reg_size,
   input  logic [RW-1:0] reg_wrdata,
   output logic          reg_done,
   output logic [RW-1:0] reg_rddata,
   output logic [1:0]    reg_err,
   // UMI host request
   output logic          uhost_req_valid,
   output logic [CW-1:0] uhost_req_cmd,
   output logic [AW-1:0] uhost_req_dstaddr,
   output logic [AW-1:0] uhost_req_srcaddr,
   output logic [DW-1:0] uhost_req_data,
   input  logic          uhost_req_ready,
   // UMI host response
   input  logic          uhost_resp_valid,
   input  logic [CW-1:0] uhost_resp_cmd,
   input  logic [AW-1:0] uhost_resp_dstaddr,
   input  logic [AW-1:0] uhost_resp_srcaddr,
   input  logic [DW-1:0] uhost_resp_data,
   output logic          uhost_resp_ready
);

   localparam logic [4:0] UMI_REQ_READ   = 5'h01;
   localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
   localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
   localparam logic [4:0] UMI_RESP_READ  = 5'h02;
   localparam logic [4:0] UMI_RESP_WRITE = 5'h04;

   localparam int            TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   state_t        next_state;
   logic          live;
   logic          cap_write;
   logic          cap_posted;
   logic [RW-1:0] cap_wrdata;
   logic [TW-1:0] tcnt;

   logic          accept;
   logic          req_fire;
   logic          resp_fire;
   logic          timeout_hit;

   logic [4:0]    resp_opcode;
   logic [4:0]    exp_opcode;
   logic [1:0]    resp_err;
   logic          resp_match;
   logic [4:0]    req_opcode;
   logic          unused_bits;

   // Request command: len=0, eom=eof=1, hostid in the top bits, rest zero.
   function automatic logic [CW-1:0] pack_req(input logic [4:0] op,
                                              input logic [2:0] size);
      logic [CW-1:0] c;
      c        = '0;
      c[4:0]   = op;
      c[7:5]   = size;
      c[22]    = 1'b1;
      c[23]    = 1'b1;
      c[31:27] = 5'(HOSTID);
      return c;
   endfunction

   assign req_opcode  = !reg_write ? UMI_REQ_READ :
                        reg_posted ? UMI_REQ_POSTED : UMI_REQ_WRITE;

   assign resp_opcode = uhost_resp_cmd[4:0];
   assign resp_err    = uhost_resp_cmd[26:25];
   assign exp_opcode  = cap_write ? UMI_RESP_WRITE : UMI_RESP_READ;
   assign resp_match  = (resp_opcode == exp_opcode) &&
                        (uhost_resp_dstaddr == uhost_req_srcaddr);

   assign unused_bits = ^{uhost_resp_srcaddr, uhost_resp_cmd, uhost_resp_data};

   assign reg_ready        = live && (state == IDLE);
   assign uhost_req_valid  = (state == REQ);
   assign uhost_resp_ready = live;
   assign uhost_req_data   = {(DW/RW){cap_wrdata}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state  = state;
      accept      = 1'b0;
      req_fire    = 1'b0;
      resp_fire   = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (reg_valid && live) begin
               accept     = 1'b1;
               next_state = REQ;
            end
         end
         REQ: begin
            if (uhost_req_ready) begin
               req_fire   = 1'b1;
               next_state = (cap_write && cap_posted) ? IDLE : RESP;
            end
         end
         RESP: begin
            // A response arriving in the expiry cycle takes priority.
            if (uhost_resp_valid) begin
               resp_fire  = 1'b1;
               next_state = IDLE;
            end else if ((TIMEOUT != 0) && (tcnt == TO_LAST)) begin
               timeout_hit = 1'b1;
               next_state  = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         live              <= 1'b0;
         cap_write         <= 1'b0;
         cap_posted        <= 1'b0;
         cap_wrdata        <= '0;
         uhost_req_cmd     <= '0;
         uhost_req_dstaddr <= '0;
         uhost_req_srcaddr <= '0;
         tcnt              <= '0;
         reg_done          <= 1'b0;
         reg_rddata        <= '0;
         reg_err           <= 2'b00;
      end else begin
         live     <= 1'b1;
         reg_done <= 1'b0;

         if (accept) begin
            cap_write         <= reg_write;
            cap_posted        <= reg_write && reg_posted;
            cap_wrdata        <= reg_wrdata;
            uhost_req_cmd     <= pack_req(req_opcode, reg_size);
            uhost_req_dstaddr <= reg_addr;
            uhost_req_srcaddr <= reg_srcaddr;
         end

         if (req_fire && cap_write && cap_posted) begin
            reg_done <= 1'b1;
            reg_err  <= 2'b00;
         end

         if (resp_fire) begin
            reg_done <= 1'b1;
            if (resp_match) begin
               reg_err <= resp_err;
               if (!cap_write) reg_rddata <= uhost_resp_data[RW-1:0];
            end else begin
               reg_err <= 2'b10;
            end
         end

         if (timeout_hit) begin
            reg_done <= 1'b1;
            reg_err  <= 2'b11;
         end

         if (req_fire)           tcnt <= '0;
         else if (state == RESP) tcnt <= tcnt + TW'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_umi_reg_host.sv
`default_nettype none
// ============================================================================
// tb_umi_reg_host : directed vector bench for umi_reg_host
// Rev 1.0
// ============================================================================
module tb_umi_reg_host;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          reg_valid = 1'b0;
   logic          reg_ready;
   logic          reg_write = 1'b0;
   logic          reg_posted = 1'b0;
   logic [63:0]   reg_addr = '0;
   logic [63:0]   reg_srcaddr = '0;
   logic [2:0]    reg_size = '0;
   logic [63:0]   reg_wrdata = '0;
   logic          reg_done;
   logic [63:0]   reg_rddata;
   logic [1:0]    reg_err;
   logic          uhost_req_valid;
   logic [31:0]   uhost_req_cmd;
   logic [63:0]   uhost_req_dstaddr;
   logic [63:0]   uhost_req_srcaddr;
   logic [255:0]  uhost_req_data;
   logic          uhost_req_ready = 1'b0;
   logic          uhost_resp_valid = 1'b0;
   logic [31:0]   uhost_resp_cmd = '0;
   logic [63:0]   uhost_resp_dstaddr = '0;
   logic [63:0]   uhost_resp_srcaddr = '0;
   logic [255:0]  uhost_resp_data = '0;
   logic          uhost_resp_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   umi_reg_host #(
      .AW(64), .CW(32), .DW(256), .RW(64), .HOSTID(21), .TIMEOUT(16)
   ) dut (
      .clk(clk), .reset(reset),
      .reg_valid(reg_valid), .reg_ready(reg_ready), .reg_write(reg_write),
      .reg_posted(reg_posted), .reg_addr(reg_addr), .reg_srcaddr(reg_srcaddr),
      .reg_size(reg_size), .reg_wrdata(reg_wrdata), .reg_done(reg_done),
      .reg_rddata(reg_rddata), .reg_err(reg_err),
      .uhost_req_valid(uhost_req_valid), .uhost_req_cmd(uhost_req_cmd),
      .uhost_req_dstaddr(uhost_req_dstaddr), .uhost_req_srcaddr(uhost_req_srcaddr),
      .uhost_req_data(uhost_req_data), .uhost_req_ready(uhost_req_ready),
      .uhost_resp_valid(uhost_resp_valid), .uhost_resp_cmd(uhost_resp_cmd),
      .uhost_resp_dstaddr(uhost_resp_dstaddr), .uhost_resp_srcaddr(uhost_resp_srcaddr),
      .uhost_resp_data(uhost_resp_data), .uhost_resp_ready(uhost_resp_ready)
   );

   typedef struct {
      logic        write;
      logic        posted;
      logic [63:0] addr;
      logic [63:0] src;
      logic [2:0]  size;
      logic [63:0] wrdata;
      int          stall;
      logic [4:0]  rop;
      logic        dst_bad;
      logic [1:0]  rerr;
      logic [63:0] rdata;
      logic [31:0] exp_cmd;
      logic [1:0]  exp_err;
      logic [63:0] exp_rd;
   } vec_t;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_req(input vec_t v);
      chk("req_valid", {255'd0, uhost_req_valid}, 256'd1);
      chk("req_cmd", {224'd0, uhost_req_cmd}, {224'd0, v.exp_cmd});
      chk("req_dstaddr", {192'd0, uhost_req_dstaddr}, {192'd0, v.addr});
      chk("req_srcaddr", {192'd0, uhost_req_srcaddr}, {192'd0, v.src});
      chk("req_data", uhost_req_data, {4{v.wrdata}});
   endtask

   task automatic run_txn(input vec_t v);
      chk("reg_ready_idle", {255'd0, reg_ready}, 256'd1);
      reg_valid   = 1'b1;
      reg_write   = v.write;
      reg_posted  = v.posted;
      reg_addr    = v.addr;
      reg_srcaddr = v.src;
      reg_size    = v.size;
      reg_wrdata  = v.wrdata;
      tick();
      reg_valid = 1'b0;
      chk("reg_ready_busy", {255'd0, reg_ready}, 256'd0);
      for (int i = 0; i < v.stall; i++) begin
         check_req(v);
         tick();
      end
      check_req(v);
      uhost_req_ready = 1'b1;
      tick();
      uhost_req_ready = 1'b0;
      if (v.write && v.posted) begin
         chk("posted_done", {255'd0, reg_done}, 256'd1);
         chk("posted_err", {254'd0, reg_err}, 256'd0);
         chk("posted_rddata", {192'd0, reg_rddata}, {192'd0, v.exp_rd});
         chk("posted_ready", {255'd0, reg_ready}, 256'd1);
      end else begin
         chk("done_early", {255'd0, reg_done}, 256'd0);
         chk("req_valid_drop", {255'd0, uhost_req_valid}, 256'd0);
         uhost_resp_valid   = 1'b1;
         uhost_resp_cmd     = 32'(v.rop) | (32'(v.rerr) << 25);
         uhost_resp_dstaddr = v.dst_bad ? (v.src ^ 64'h10) : v.src;
         uhost_resp_data    = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                               64'hCCCC_CCCC_CCCC_CCCC, v.rdata};
         tick();
         uhost_resp_valid = 1'b0;
         chk("resp_done", {255'd0, reg_done}, 256'd1);
         chk("resp_err", {254'd0, reg_err}, {254'd0, v.exp_err});
         chk("resp_rddata", {192'd0, reg_rddata}, {192'd0, v.exp_rd});
         chk("resp_ready_next", {255'd0, reg_ready}, 256'd1);
      end
      tick();
      chk("done_pulse", {255'd0, reg_done}, 256'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      vec_t v;
      int   n;

      //         wr   pst  addr        src             sz    wrdata  stall rop    bad   rerr   rdata                      exp_cmd       err    exp_rd
      vecs[0] = '{1'b0,1'b0,64'h1000, 64'h8000_0000, 3'd3, 64'h0,  0, 5'h02, 1'b0, 2'b00, 64'h1234_5678_9ABC_DEF0, 32'hA8C0_0061, 2'b00, 64'h1234_5678_9ABC_DEF0};
      vecs[1] = '{1'b1,1'b0,64'h100,  64'h8000_0040, 3'd2, 64'hA5, 4, 5'h04, 1'b0, 2'b00, 64'hDEAD_BEEF,            32'hA8C0_0043, 2'b00, 64'h1234_5678_9ABC_DEF0};
      vecs[2] = '{1'b1,1'b1,64'h200,  64'h8000_0080, 3'd0, 64'h5A, 0, 5'h00, 1'b0, 2'b00, 64'h0,                    32'hA8C0_0005, 2'b00, 64'h1234_5678_9ABC_DEF0};
      vecs[3] = '{1'b0,1'b0,64'h300,  64'h8000_00C0, 3'd3, 64'h1,  0, 5'h04, 1'b0, 2'b00, 64'h1111,                 32'hA8C0_0061, 2'b10, 64'h1234_5678_9ABC_DEF0};
      vecs[4] = '{1'b0,1'b0,64'h400,  64'h8000_0100, 3'd3, 64'h2,  0, 5'h02, 1'b1, 2'b00, 64'h2222,                 32'hA8C0_0061, 2'b10, 64'h1234_5678_9ABC_DEF0};
      vecs[5] = '{1'b0,1'b0,64'h500,  64'h8000_0140, 3'd0, 64'h3,  0, 5'h02, 1'b0, 2'b01, 64'hCAFE_F00D,            32'hA8C0_0001, 2'b01, 64'hCAFE_F00D};
      vecs[6] = '{1'b1,1'b0,64'h600,  64'h8000_0180, 3'd3, 64'h77, 0, 5'h02, 1'b0, 2'b00, 64'h3333,                 32'hA8C0_0063, 2'b10, 64'hCAFE_F00D};

      // reset values while reset is held
      #11;
      chk("rst_reg_ready", {255'd0, reg_ready}, 256'd0);
      chk("rst_resp_ready", {255'd0, uhost_resp_ready}, 256'd0);
      chk("rst_req_valid", {255'd0, uhost_req_valid}, 256'd0);
      chk("rst_done", {255'd0, reg_done}, 256'd0);
      chk("rst_cmd", {224'd0, uhost_req_cmd}, 256'd0);
      reset = 1'b0;
      tick();
      chk("post_rst_ready", {255'd0, reg_ready}, 256'd1);
      chk("post_rst_resp_ready", {255'd0, uhost_resp_ready}, 256'd1);

      for (int i = 0; i < 7; i++) run_txn(vecs[i]);

      // timeout: read with no response
      reg_valid = 1'b1; reg_write = 1'b0; reg_posted = 1'b0;
      reg_addr = 64'h700; reg_srcaddr = 64'h8000_01C0; reg_size = 3'd3; reg_wrdata = 64'h0;
      tick();
      reg_valid = 1'b0;
      uhost_req_ready = 1'b1;
      tick();
      uhost_req_ready = 1'b0;
      n = 0;
      while (!reg_done && n < 40) begin
         tick();
         n++;
      end
      chk("timeout_cycles", 256'(n), 256'd16);
      chk("timeout_err", {254'd0, reg_err}, 256'd3);
      chk("timeout_rddata", {192'd0, reg_rddata}, {192'd0, 64'hCAFE_F00D});

      // late response while idle is swallowed
      chk("stray_resp_ready", {255'd0, uhost_resp_ready}, 256'd1);
      uhost_resp_valid   = 1'b1;
      uhost_resp_cmd     = 32'h2;
      uhost_resp_dstaddr = 64'h8000_01C0;
      uhost_resp_data    = {192'd0, 64'h9999};
      tick();
      uhost_resp_valid = 1'b0;
      chk("stray_no_done", {255'd0, reg_done}, 256'd0);
      chk("stray_rddata", {192'd0, reg_rddata}, {192'd0, 64'hCAFE_F00D});

      v = '{1'b0,1'b0,64'h800, 64'h8000_0200, 3'd3, 64'h0, 0, 5'h02, 1'b0, 2'b00,
            64'hFEDC_BA98_7654_3210, 32'hA8C0_0061, 2'b00, 64'hFEDC_BA98_7654_3210};
      run_txn(v);

      // reset while waiting for a response
      reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 64'h900; reg_srcaddr = 64'h8000_0240;
      tick();
      reg_valid = 1'b0;
      uhost_req_ready = 1'b1;
      tick();
      uhost_req_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk("midrst_ready", {255'd0, reg_ready}, 256'd0);
      chk("midrst_done", {255'd0, reg_done}, 256'd0);
      chk("midrst_rddata", {192'd0, reg_rddata}, 256'd0);
      chk("midrst_err", {254'd0, reg_err}, 256'd0);
      chk("midrst_req_valid", {255'd0, uhost_req_valid}, 256'd0);
      chk("midrst_dstaddr", {192'd0, uhost_req_dstaddr}, 256'd0);
      chk("midrst_resp_ready", {255'd0, uhost_resp_ready}, 256'd0);
      tick();
      reset = 1'b0;
      tick();
      chk("midrst_release_ready", {255'd0, reg_ready}, 256'd1);
      v = '{1'b0,1'b0,64'hA00, 64'h8000_0280, 3'd3, 64'h0, 0, 5'h02, 1'b0, 2'b00,
            64'h0BAD_C0DE_0000_0001, 32'hA8C0_0061, 2'b00, 64'h0BAD_C0DE_0000_0001};
      run_txn(v);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
